// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter sequencer with condition flags,
// circular return-address stack, halt and stall handling.
module pc_seq_unit #(
  parameter int PC_W = 16,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic [2:0]      cond,
  input  logic [PC_W-1:0] imm_b,
  input  logic [PC_W-1:0] imm_c,
  input  logic            set_zero,
  input  logic            set_ovf,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link,
  output logic [2:0]      flags,
  output logic            hlt,
  output logic            ras_ovf,
  output logic            ras_udf
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [PC_W-1:0] ras [RAS_DEPTH];
  logic [AW-1:0]   sp;
  logic [CW-1:0]   cnt;

  logic            fz, fv, fn;
  logic            take, live, empty, full;
  logic            sel_h, sel_r, sel_c, sel_b;
  logic            do_ret, do_call;
  logic [PC_W-1:0] pc_inc, top, pc_nxt;

  assign pc_inc = pc + PC_W'(1);
  assign link = pc_inc;
  assign {fz, fv, fn} = flags;
  assign top = ras[sp - AW'(1)];
  assign empty = (cnt == '0);
  assign full = (cnt == FULL);
  assign live = !stall && !hlt;

  // One-hot request selects in priority order.
  assign sel_h = halt;
  assign sel_r = ret && !halt;
  assign sel_c = call && !ret && !halt;
  assign sel_b = branch && take && !call && !ret && !halt;

  assign do_ret = live && sel_r;
  assign do_call = live && sel_c;

  // Branch condition against flags held from earlier cycles.
  always_comb begin
    take = 1'b0;
    unique case (cond)
      3'b000: take = !fz;
      3'b001: take = fz;
      3'b010: take = !fz && !fn;
      3'b011: take = fn;
      3'b100: take = fz || !fn;
      3'b101: take = fz || fn;
      3'b110: take = fv;
      3'b111: take = 1'b1;
    endcase
  end

  // Next-PC select.
  always_comb begin
    pc_nxt = pc_inc;
    unique case (1'b1)
      sel_h: pc_nxt = pc;
      sel_r: pc_nxt = empty ? pc_inc : top;
      sel_c: pc_nxt = pc_inc + imm_c;
      sel_b: pc_nxt = pc_inc + imm_b;
      default: pc_nxt = pc_inc;
    endcase
  end

  // Control state: pc, flags, stack count/pointer, sticky bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      flags <= '0;
      sp <= '0;
      cnt <= '0;
      hlt <= 1'b0;
      ras_ovf <= 1'b0;
      ras_udf <= 1'b0;
    end else if (live) begin
      pc <= pc_nxt;
      if (halt) hlt <= 1'b1;
      if (set_zero) flags[2] <= alu_z;
      if (set_ovf) flags[1:0] <= {alu_v, alu_n};
      if (do_ret) begin
        if (empty) begin
          ras_udf <= 1'b1;
        end else begin
          sp <= sp - AW'(1);
          cnt <= cnt - CW'(1);
        end
      end else if (do_call) begin
        sp <= sp + AW'(1);
        if (full) ras_ovf <= 1'b1;
        else cnt <= cnt + CW'(1);
      end
    end
  end

  // Stack storage; a full stack overwrites its oldest slot.
  always_ff @(posedge clk) begin
    if (rst_n && do_call) ras[sp] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: scoreboard bench for pc_seq_unit.
// Expected PCs are queued at drive time and popped after the edge.
module tb_pc_seq_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         branch = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic         halt = 1'b0;
  logic [2:0]   cond = 3'b000;
  logic [W-1:0] imm_b = '0;
  logic [W-1:0] imm_c = '0;
  logic         set_zero = 1'b0;
  logic         set_ovf = 1'b0;
  logic         alu_z = 1'b0;
  logic         alu_v = 1'b0;
  logic         alu_n = 1'b0;
  logic [W-1:0] pc, link;
  logic [2:0]   flags;
  logic         hlt, ras_ovf, ras_udf;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  always #5 clk = ~clk;

  pc_seq_unit #(.PC_W(W), .RAS_DEPTH(4), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch(branch), .call(call), .ret(ret), .halt(halt),
    .cond(cond), .imm_b(imm_b), .imm_c(imm_c),
    .set_zero(set_zero), .set_ovf(set_ovf),
    .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .pc(pc), .link(link), .flags(flags), .hlt(hlt),
    .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch = 0; call = 0; ret = 0; halt = 0;
    set_zero = 0; set_ovf = 0; alu_z = 0; alu_v = 0; alu_n = 0;
    cond = 3'b000;
  endtask

  // Reset, then branch-always from pc 0 to t.
  task automatic goto(input logic [W-1:0] t);
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    branch = 1; cond = 3'b111; imm_b = t - 16'd1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    total++;
    if (pc !== 16'h0000 || flags !== 3'b000 || hlt !== 1'b0 ||
        ras_ovf !== 1'b0 || ras_udf !== 1'b0) begin
      bad++;
      $display("FAIL reset pc=%h fl=%b h=%b o=%b u=%b want 0000 000 0 0 0",
               pc, flags, hlt, ras_ovf, ras_udf);
    end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(W'(i));
      tick();
      e = exp_q.pop_front();
      total++;
      if (pc !== e) begin
        bad++;
        $display("FAIL idle_%0d pc=%h want=%h", i, pc, e);
      end
    end
    total++;
    if (link !== 16'h0004) begin
      bad++;
      $display("FAIL link got=%h want=0004", link);
    end
  endtask

  // z=1 set at 0x10; branch issued at 0x11.
  task automatic test_branch(input logic [2:0] c, input logic upd,
                             input logic [W-1:0] want, input string nm);
    goto(16'h0010);
    set_zero = 1; alu_z = 1;
    tick();
    idle();
    total++;
    if (flags !== 3'b100) begin
      bad++;
      $display("FAIL %s_flags got=%b want=100", nm, flags);
    end
    branch = 1; cond = c; imm_b = 16'h0005;
    if (upd) begin set_zero = 1; alu_z = 0; end
    exp_q.push_back(want);
    tick();
    idle();
    e = exp_q.pop_front();
    total++;
    if (pc !== e) begin
      bad++;
      $display("FAIL %s pc=%h want=%h", nm, pc, e);
    end
  endtask

  task automatic test_flags_n();
    goto(16'h0010);
    set_ovf = 1; alu_v = 0; alu_n = 1;
    tick();
    idle();
    total++;
    if (flags !== 3'b001) begin
      bad++;
      $display("FAIL n_flags got=%b want=001", flags);
    end
    branch = 1; cond = 3'b011; imm_b = 16'h0020;
    exp_q.push_back(16'h0032);
    tick();
    branch = 1; cond = 3'b110; imm_b = 16'h0020;
    exp_q.push_back(16'h0033);
    tick();
    idle();
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    total++;
    if (pc !== e) begin
      bad++;
      $display("FAIL lt_then_ov pc=%h want=%h", pc, e);
    end
  endtask

  task automatic test_call_ret();
    goto(16'h0020);
    total++;
    if (link !== 16'h0021) begin
      bad++;
      $display("FAIL call_link got=%h want=0021", link);
    end
    call = 1; imm_c = 16'h0100;
    exp_q.push_back(16'h0121);
    tick();
    idle();
    e = exp_q.pop_front();
    total++;
    if (pc !== e) begin
      bad++;
      $display("FAIL call pc=%h want=%h", pc, e);
    end
    tick();
    tick();
    ret = 1;
    exp_q.push_back(16'h0021);
    exp_q.push_back(16'h0022);
    tick();
    e = exp_q.pop_front();
    total++;
    if (pc !== e || ras_udf !== 1'b0) begin
      bad++;
      $display("FAIL ret pc=%h u=%b want=%h 0", pc, ras_udf, e);
    end
    tick();
    idle();
    e = exp_q.pop_front();
    total++;
    if (pc !== e || ras_udf !== 1'b1) begin
      bad++;
      $display("FAIL ret_empty pc=%h u=%b want=%h 1", pc, ras_udf, e);
    end
  endtask

  // Nested calls past capacity, then unwind; model keeps newest four.
  task automatic test_overflow();
    logic [W-1:0] mpc;
    logic [W-1:0] mstk[$];
    goto(16'h0100);
    mpc = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      call = 1; imm_c = 16'h0010;
      mstk.push_back(mpc + 16'd1);
      if (mstk.size() > 4) void'(mstk.pop_front());
      mpc = mpc + 16'h0011;
      exp_q.push_back(mpc);
      tick();
      e = exp_q.pop_front();
      total++;
      if (pc !== e) begin
        bad++;
        $display("FAIL nest_call_%0d pc=%h want=%h", i, pc, e);
      end
    end
    idle();
    total++;
    if (ras_ovf !== 1'b1 || ras_udf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_flag o=%b u=%b want 1 0", ras_ovf, ras_udf);
    end
    for (int i = 0; i < 5; i++) begin
      ret = 1;
      if (mstk.size() > 0) mpc = mstk.pop_back();
      else mpc = mpc + 16'd1;
      exp_q.push_back(mpc);
      tick();
      e = exp_q.pop_front();
      total++;
      if (pc !== e) begin
        bad++;
        $display("FAIL nest_ret_%0d pc=%h want=%h", i, pc, e);
      end
    end
    idle();
    total++;
    if (ras_udf !== 1'b1) begin
      bad++;
      $display("FAIL udf_flag got=%b want=1", ras_udf);
    end
  endtask

  task automatic test_wrap();
    goto(16'hFFFF);
    exp_q.push_back(16'h0000);
    tick();
    e = exp_q.pop_front();
    total++;
    if (pc !== e) begin
      bad++;
      $display("FAIL wrap pc=%h want=%h", pc, e);
    end
  endtask

  task automatic test_halt();
    goto(16'h0040);
    halt = 1;
    tick();
    idle();
    total++;
    if (hlt !== 1'b1 || pc !== 16'h0040) begin
      bad++;
      $display("FAIL halt h=%b pc=%h want 1 0040", hlt, pc);
    end
    for (int i = 0; i < 10; i++) begin
      branch = 1; cond = 3'b111; imm_b = 16'h0300;
      call = (i % 2) == 0; imm_c = 16'h0200;
      set_zero = 1; alu_z = 1; set_ovf = 1; alu_v = 1; alu_n = 1;
      exp_q.push_back(16'h0040);
      tick();
      e = exp_q.pop_front();
      total++;
      if (pc !== e || hlt !== 1'b1 || flags !== 3'b000) begin
        bad++;
        $display("FAIL halted_%0d pc=%h h=%b fl=%b want %h 1 000",
                 i, pc, hlt, flags, e);
      end
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    idle();
    total++;
    if (pc !== 16'h0000 || hlt !== 1'b0) begin
      bad++;
      $display("FAIL reset_halted pc=%h h=%b want 0000 0", pc, hlt);
    end
  endtask

  task automatic test_stall();
    goto(16'h0030);
    for (int i = 0; i < 3; i++) begin
      stall = 1; call = 1; imm_c = 16'h0010; halt = (i == 1);
      set_zero = 1; alu_z = 1;
      exp_q.push_back(16'h0030);
      tick();
      e = exp_q.pop_front();
      total++;
      if (pc !== e || hlt !== 1'b0 || flags !== 3'b000) begin
        bad++;
        $display("FAIL stall_%0d pc=%h h=%b fl=%b want %h 0 000",
                 i, pc, hlt, flags, e);
      end
    end
    idle();
    call = 1; imm_c = 16'h0010;
    exp_q.push_back(16'h0041);
    tick();
    idle();
    ret = 1;
    exp_q.push_back(16'h0031);
    tick();
    exp_q.push_back(16'h0032);
    tick();
    idle();
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    total++;
    if (e !== 16'h0031) begin
      bad++;
      $display("FAIL sb_order got=%h want=0031", e);
    end
    e = exp_q.pop_front();
    total++;
    if (pc !== e || ras_udf !== 1'b1) begin
      bad++;
      $display("FAIL stall_push pc=%h u=%b want %h 1", pc, ras_udf, e);
    end
  endtask

  initial begin
    test_reset();
    test_branch(3'b001, 1'b0, 16'h0017, "br_eq");
    test_branch(3'b000, 1'b0, 16'h0012, "br_ne");
    test_branch(3'b010, 1'b0, 16'h0012, "br_gt");
    test_branch(3'b001, 1'b1, 16'h0017, "br_old_flags");
    test_flags_n();
    test_call_ret();
    test_overflow();
    test_wrap();
    test_halt();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
